usb_hid_kbd_report_rx: RTL and testbench
========================================

Name: usb_hid_kbd_report_rx

Overview:
- Receive side of the HID keyboard path. Consumes the byte stream delivered by usbfs_core_top's OUT endpoint (out_data/out_valid).
- Assembles 8-byte boot-keyboard reports (byte0 modifiers, byte1 reserved, bytes2..7 keycodes). Diffs each report against the previous one.
- Emits one press/release event per changed keycode over a valid/ready stream. Used for loopback test benches and for boards that accept keyboard reports from a host.

Parameters:
- GAP_TIMEOUT, 16'd1000, idle clk cycles allowed between bytes of one report before the partial report is discarded.

Ports:
- clk  input  1  60MHz core clock
- rstn  input  1  asynchronous active-low reset
- usb_rstn  input  1  synchronous active-low clear from usbfs_core_top (USB bus reset)
- out_data  input  8  received payload byte
- out_valid  input  1  out_data valid this cycle; no backpressure
- evt_valid  output  1  event available
- evt_ready  input  1  consumer accepts event
- evt_press  output  1  1=key pressed, 0=key released
- evt_code  output  8  HID usage code of the event
- modifiers  output  8  byte0 of the last committed report
- err_frag  output  1  1-cycle pulse: partial report discarded by timeout
- err_overrun  output  1  1-cycle pulse: pending report overwritten before being processed
- err_rollover  output  1  1-cycle pulse: ErrorRollOver report ignored

Behaviour:
- Reset (rstn=0 async, or usb_rstn=0 sync): all outputs 0. Byte counter, gap counter, prev/cur/pending buffers cleared, FSM=IDLE. No release events are generated for keys held at reset.
- Assembly:
  - A 3-bit byte counter takes each out_valid byte into asm[cnt]. Counter wraps 7->0 on the 8th byte, which completes a report.
  - The gap counter is cleared on every out_valid and increments while cnt!=0.
  - When the gap counter reaches GAP_TIMEOUT: cnt<=0, asm discarded, err_frag pulses.
- Pending slot (one-deep):
  - A completed report goes to the pending slot, pend_full<=1.
  - If pend_full is already 1, the slot is overwritten and err_overrun pulses.
  - Assembly never stalls.
- FSM states: IDLE, REL_SCAN, PRS_SCAN, EMIT_REL, EMIT_PRS.
  - IDLE, pend_full=1, all 6 keycodes==8'h01: pending is dropped, err_rollover pulses, prev and modifiers are unchanged, FSM stays in IDLE.
  - IDLE, pend_full=1, otherwise (commit): cur<=pending keycodes, modifiers<=pending byte0, pend_full<=0, i<=0, go to REL_SCAN. If a report completes in the same cycle, it lands in the slot with no overrun.
  - REL_SCAN examines one index i per cycle. Release condition: prev[i]!=0, prev[i] not in cur[0..5], and prev[i]!=prev[j] for all j<i. If met: evt_press<=0, evt_code<=prev[i], evt_valid<=1, go to EMIT_REL. Else i++. After i=5: i<=0, go to PRS_SCAN.
  - PRS_SCAN: same rule on cur against prev, with evt_press<=1, going to EMIT_PRS. After i=5: prev<=cur, go to IDLE.
  - EMIT_*: evt_valid, evt_press and evt_code are held stable until evt_valid&&evt_ready. Then evt_valid<=0, i++ (or exit as above when i=5), and return to the matching scan state.
- Latency:
  - Byte 8 is accepted at cycle T with FSM idle and no pending report.
  - pend_full=1 at T+1, commit at T+2 (modifiers updates at T+2), first evt_valid at T+3 at the earliest.
  - Each event costs at least 2 cycles.
  - Worst case with no backpressure: 12 scan cycles plus 12 handshakes per report.
- Ordering: all releases precede all presses within a report. Within each group, events come out in ascending index order.
- Error pulses are registered, fire in the cycle after their cause, and are mutually independent.

Decomposition:
- Package usb_hid_pkg holds:
  - REPORT_LEN=8, NKEYS=6
  - KEY_ERR_ROLLOVER=8'h01
  - typedef keybuf_t (array [6] of 8-bit)
  - the FSM enum
- Sub-module usb_hid_key_match: combinational. Inputs: 8-bit code and a keybuf_t. Output: found. Two instances, one per scan direction.

Test Plan:
- Press/release: send report 00 00 04 00 00 00 00 00 -> exactly one event press 0x04. Then send all-zero report -> exactly one event release 0x04, modifiers=00.
- Modifier and multiple keys: send 02 00 04 05 00 00 00 00, then 02 00 05 06 00 00 00 00 -> modifiers=02; events press 04, press 05, then release 04, press 06.
- Backpressure: hold evt_ready=0 for 50 cycles during the first event -> evt_valid=1 and evt_code/evt_press stable throughout. Then 1-cycle evt_ready -> next event appears; no loss and no duplication.
- Fragment: send 3 bytes then stay idle for 1000 cycles -> err_frag pulse; a following full report 00 00 1E 00 00 00 00 00 yields press 0x1E.
- Rollover and overrun:
  - Report 00 00 01 01 01 01 01 01 -> err_rollover, no events.
  - With evt_ready=0, send three full reports -> err_overrun once; after release of evt_ready, only the first and third reports are processed.
- Reset mid-operation: pull usb_rstn low while in EMIT_PRS -> evt_valid=0 the next cycle, modifiers=0. The next report 00 00 04 ... reports press 0x04 again.

Source files
------------

// File: rtl/usb_hid_pkg.sv
// Shared types and constants for the HID boot-keyboard report receiver.
package usb_hid_pkg;

  localparam int REPORT_LEN = 8;
  localparam int NKEYS      = 6;

  localparam logic [7:0] KEY_ERR_ROLLOVER = 8'h01;

  // Six keycode slots of a boot-keyboard report (bytes 2..7).
  typedef logic [NKEYS-1:0][7:0] keybuf_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REL_SCAN,
    ST_PRS_SCAN,
    ST_EMIT_REL,
    ST_EMIT_PRS
  } kbd_state_e;

endpackage

// File: rtl/usb_hid_key_match.sv
// Combinational membership test: is code present anywhere in keys?
module usb_hid_key_match
  import usb_hid_pkg::*;
(
  input  logic [7:0] code,
  input  keybuf_t    keys,
  output logic       found
);

  // Compare the code against every slot of the buffer.
  always_comb begin
    found = 1'b0;
    for (int k = 0; k < NKEYS; k++) begin
      if (keys[k] == code) found = 1'b1;
    end
  end

endmodule

// File: rtl/usb_hid_kbd_report_rx.sv
// HID boot-keyboard report receiver: assembles 8-byte reports from the OUT
// endpoint byte stream, diffs them against the previous report and emits one
// press/release event per changed keycode (releases first, ascending index).
module usb_hid_kbd_report_rx
  import usb_hid_pkg::*;
#(
  parameter logic [15:0] GAP_TIMEOUT = 16'd1000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       usb_rstn,
  input  logic [7:0] out_data,
  input  logic       out_valid,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic       evt_press,
  output logic [7:0] evt_code,
  output logic [7:0] modifiers,
  output logic       err_frag,
  output logic       err_overrun,
  output logic       err_rollover
);

  kbd_state_e  state, state_n;
  logic [2:0]  cnt;
  logic [15:0] gap;
  logic [7:0]  asm_mod;
  keybuf_t     asm_keys, done_keys;
  logic [7:0]  pend_mod;
  keybuf_t     pend_keys;
  logic        pend_full;
  keybuf_t     cur, prev;
  logic [2:0]  idx, idx_n;

  logic        rpt_done, pend_ro, pend_take, hs, idx_last;
  logic [7:0]  prev_key, cur_key;
  logic        rel_found, prs_found, rel_dup, prs_dup, rel_hit, prs_hit;
  logic        take_commit, take_drop, prev_load;
  logic        evt_set, evt_set_press, evt_clr;
  logic [7:0]  evt_set_code;

  assign rpt_done  = out_valid && (cnt == 3'(REPORT_LEN - 1));
  assign hs        = evt_valid && evt_ready;
  assign idx_last  = (idx == 3'(NKEYS - 1));
  assign prev_key  = prev[idx];
  assign cur_key   = cur[idx];
  assign pend_take = take_commit || take_drop;

  // A released key must be absent from the new report, a pressed key absent from the old one.
  usb_hid_key_match u_rel_match (.code(prev_key), .keys(cur),  .found(rel_found));
  usb_hid_key_match u_prs_match (.code(cur_key),  .keys(prev), .found(prs_found));

  // Final byte goes straight into the slot; rollover detection; duplicate suppression.
  always_comb begin
    done_keys    = asm_keys;
    done_keys[5] = out_data;
    pend_ro      = 1'b1;
    rel_dup      = 1'b0;
    prs_dup      = 1'b0;
    for (int j = 0; j < NKEYS; j++) begin
      if (pend_keys[j] != KEY_ERR_ROLLOVER) pend_ro = 1'b0;
      if (3'(j) < idx) begin
        if (prev[j] == prev_key) rel_dup = 1'b1;
        if (cur[j] == cur_key)   prs_dup = 1'b1;
      end
    end
    rel_hit = (prev_key != 8'h00) && !rel_found && !rel_dup;
    prs_hit = (cur_key != 8'h00) && !prs_found && !prs_dup;
  end

  // Byte assembly with inter-byte gap timeout.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0; gap <= '0; asm_mod <= '0; asm_keys <= '0; err_frag <= 1'b0;
    end else if (!usb_rstn) begin
      cnt <= '0; gap <= '0; asm_mod <= '0; asm_keys <= '0; err_frag <= 1'b0;
    end else begin
      err_frag <= 1'b0;
      if (out_valid) begin
        gap <= '0;
        cnt <= cnt + 3'd1;
        if (cnt == 3'd0) asm_mod <= out_data;
        else if (cnt != 3'd1) asm_keys[cnt - 3'd2] <= out_data;
      end else if (cnt != 3'd0) begin
        if (gap == GAP_TIMEOUT) begin
          cnt      <= '0;
          gap      <= '0;
          err_frag <= 1'b1;
        end else begin
          gap <= gap + 16'd1;
        end
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else if (!usb_rstn) state <= ST_IDLE;
    else state <= state_n;
  end

  // FSM next state and datapath controls.
  always_comb begin
    state_n       = state;
    idx_n         = idx;
    take_commit   = 1'b0;
    take_drop     = 1'b0;
    prev_load     = 1'b0;
    evt_set       = 1'b0;
    evt_set_press = 1'b0;
    evt_set_code  = 8'h00;
    evt_clr       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pend_full) begin
          if (pend_ro) take_drop = 1'b1;
          else begin
            take_commit = 1'b1;
            idx_n       = '0;
            state_n     = ST_REL_SCAN;
          end
        end
      end
      ST_REL_SCAN: begin
        if (rel_hit) begin
          evt_set      = 1'b1;
          evt_set_code = prev_key;
          state_n      = ST_EMIT_REL;
        end else if (idx_last) begin
          idx_n   = '0;
          state_n = ST_PRS_SCAN;
        end else idx_n = idx + 3'd1;
      end
      ST_PRS_SCAN: begin
        if (prs_hit) begin
          evt_set       = 1'b1;
          evt_set_press = 1'b1;
          evt_set_code  = cur_key;
          state_n       = ST_EMIT_PRS;
        end else if (idx_last) begin
          idx_n     = '0;
          prev_load = 1'b1;
          state_n   = ST_IDLE;
        end else idx_n = idx + 3'd1;
      end
      ST_EMIT_REL: begin
        if (hs) begin
          evt_clr = 1'b1;
          if (idx_last) begin
            idx_n   = '0;
            state_n = ST_PRS_SCAN;
          end else begin
            idx_n   = idx + 3'd1;
            state_n = ST_REL_SCAN;
          end
        end
      end
      ST_EMIT_PRS: begin
        if (hs) begin
          evt_clr = 1'b1;
          if (idx_last) begin
            idx_n     = '0;
            prev_load = 1'b1;
            state_n   = ST_IDLE;
          end else begin
            idx_n   = idx + 3'd1;
            state_n = ST_PRS_SCAN;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Pending slot, key buffers, event register and overrun/rollover pulses.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend_mod <= '0; pend_keys <= '0; pend_full <= 1'b0; cur <= '0; prev <= '0;
      modifiers <= '0; idx <= '0; evt_valid <= 1'b0; evt_press <= 1'b0; evt_code <= '0;
      err_overrun <= 1'b0; err_rollover <= 1'b0;
    end else if (!usb_rstn) begin
      pend_mod <= '0; pend_keys <= '0; pend_full <= 1'b0; cur <= '0; prev <= '0;
      modifiers <= '0; idx <= '0; evt_valid <= 1'b0; evt_press <= 1'b0; evt_code <= '0;
      err_overrun <= 1'b0; err_rollover <= 1'b0;
    end else begin
      err_overrun  <= 1'b0;
      err_rollover <= take_drop;
      // A report completing while the slot is being taken is not an overrun.
      if (rpt_done) begin
        pend_mod    <= asm_mod;
        pend_keys   <= done_keys;
        pend_full   <= 1'b1;
        err_overrun <= pend_full && !pend_take;
      end else if (pend_take) begin
        pend_full <= 1'b0;
      end
      if (take_commit) begin
        cur       <= pend_keys;
        modifiers <= pend_mod;
      end
      if (prev_load) prev <= cur;
      idx <= idx_n;
      if (evt_set) begin
        evt_valid <= 1'b1;
        evt_press <= evt_set_press;
        evt_code  <= evt_set_code;
      end else if (evt_clr) begin
        evt_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_usb_hid_kbd_report_rx.sv
// Randomized and directed bench for usb_hid_kbd_report_rx with a
// report-level reference model (expected event queue from report diffs).
module tb_usb_hid_kbd_report_rx;

  logic       clk = 1'b0;
  logic       rstn, usb_rstn;
  logic [7:0] out_data;
  logic       out_valid;
  logic       evt_valid, evt_ready, evt_press;
  logic [7:0] evt_code, modifiers;
  logic       err_frag, err_overrun, err_rollover;

  usb_hid_kbd_report_rx #(.GAP_TIMEOUT(16'd1000)) dut (
    .clk(clk), .rstn(rstn), .usb_rstn(usb_rstn),
    .out_data(out_data), .out_valid(out_valid),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_press(evt_press),
    .evt_code(evt_code), .modifiers(modifiers),
    .err_frag(err_frag), .err_overrun(err_overrun), .err_rollover(err_rollover)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       press;
    logic [7:0] code;
    logic [7:0] mods;
  } evt_t;

  evt_t       exp_q[$];
  logic [7:0] rep [8];
  logic [7:0] m_prev [6];
  logic [7:0] m_mod;
  int n_vec = 0, n_miss = 0;
  int exp_frag = 0, exp_ro = 0, exp_ovr = 0;
  int cnt_frag = 0, cnt_ro = 0, cnt_ovr = 0;
  int rdy_mode = 0;  // 0 always ready, 1 never, 2 random, 3 manual
  logic       hold_q = 1'b0, hold_press;
  logic [7:0] hold_code;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, req);
    end
  endfunction

  // Reference model: diff the report in rep against the last committed keys.
  task automatic model_report();
    logic [7:0] nk [6];
    bit all_ro, dup, hit;
    all_ro = 1'b1;
    for (int i = 0; i < 6; i++) begin
      nk[i] = rep[i+2];
      if (nk[i] != 8'h01) all_ro = 1'b0;
    end
    if (all_ro) begin
      exp_ro++;
      return;
    end
    m_mod = rep[0];
    for (int i = 0; i < 6; i++) begin
      dup = 0; hit = 0;
      for (int j = 0; j < i; j++) if (m_prev[j] == m_prev[i]) dup = 1;
      for (int k = 0; k < 6; k++) if (nk[k] == m_prev[i]) hit = 1;
      if (m_prev[i] != 8'h00 && !dup && !hit) exp_q.push_back('{1'b0, m_prev[i], m_mod});
    end
    for (int i = 0; i < 6; i++) begin
      dup = 0; hit = 0;
      for (int j = 0; j < i; j++) if (nk[j] == nk[i]) dup = 1;
      for (int k = 0; k < 6; k++) if (m_prev[k] == nk[i]) hit = 1;
      if (nk[i] != 8'h00 && !dup && !hit) exp_q.push_back('{1'b1, nk[i], m_mod});
    end
    for (int i = 0; i < 6; i++) m_prev[i] = nk[i];
  endtask

  // Compare process: event handshakes, hold stability, error pulse counts.
  always @(negedge clk) begin
    evt_t e;
    if (rstn && usb_rstn) begin
      if (hold_q) begin
        check("hold_valid", 32'(evt_valid), 32'd1);
        check("hold_code", 32'(evt_code), 32'(hold_code));
        check("hold_press", 32'(evt_press), 32'(hold_press));
      end
      if (evt_valid && evt_ready) begin
        if (exp_q.size() == 0) check("evt_unexpected_code", 32'(evt_code), 32'd0);
        else begin
          e = exp_q.pop_front();
          check("evt_press", 32'(evt_press), 32'(e.press));
          check("evt_code", 32'(evt_code), 32'(e.code));
          check("evt_modifiers", 32'(modifiers), 32'(e.mods));
        end
      end
      if (err_frag) cnt_frag++;
      if (err_rollover) cnt_ro++;
      if (err_overrun) cnt_ovr++;
      hold_q    = evt_valid && !evt_ready;
      hold_code = evt_code;
      hold_press = evt_press;
    end else begin
      hold_q = 1'b0;
    end
  end

  // Ready driver for the automatic modes.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: evt_ready = 1'b1;
      1: evt_ready = 1'b0;
      2: evt_ready = 1'($urandom_range(0, 1));
      default: ;
    endcase
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic load_rep(input logic [63:0] v);
    for (int b = 0; b < 8; b++) rep[b] = v[63-8*b -: 8];
  endtask

  task automatic send_report(input int max_gap);
    for (int b = 0; b < 8; b++) begin
      out_data = rep[b]; out_valid = 1'b1;
      tick(1);
      out_valid = 1'b0;
      if (b < 7 && max_gap > 0) tick($urandom_range(0, max_gap));
    end
  endtask

  task automatic wait_valid(input int maxc, output int lat);
    lat = 1;
    while (!evt_valid && lat < maxc) begin tick(1); lat++; end
    if (!evt_valid) check("evt_valid_timeout", 32'(evt_valid), 32'd1);
  endtask

  task automatic wait_drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 3000) begin tick(1); k++; end
    if (exp_q.size() != 0) begin
      check("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    tick(20);
    check("idle_valid", 32'(evt_valid), 32'd0);
    check("idle_modifiers", 32'(modifiers), 32'(m_mod));
  endtask

  function automatic logic [7:0] rnd_key();
    int r = $urandom_range(0, 11);
    if (r < 3) return 8'h00;
    if (r == 3) return 8'h01;
    return 8'(r);
  endfunction

  initial begin
    #3000000;
    $display("FAIL watchdog: run exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    rstn = 1'b0; usb_rstn = 1'b1; out_valid = 1'b0; out_data = 8'h00; evt_ready = 1'b1;
    m_mod = 8'h00;
    for (int i = 0; i < 6; i++) m_prev[i] = 8'h00;
    tick(3);
    check("rst_evt_valid", 32'(evt_valid), 32'd0);
    check("rst_evt_press", 32'(evt_press), 32'd0);
    check("rst_evt_code", 32'(evt_code), 32'd0);
    check("rst_modifiers", 32'(modifiers), 32'd0);
    check("rst_err_frag", 32'(err_frag), 32'd0);
    check("rst_err_overrun", 32'(err_overrun), 32'd0);
    check("rst_err_rollover", 32'(err_rollover), 32'd0);
    rstn = 1'b1;
    tick(3);

    // Single press, then release; first-event latency pinned by hand.
    load_rep(64'h00_00_04_00_00_00_00_00);
    send_report(0); model_report();
    wait_valid(40, lat);
    check("press_latency", 32'(lat), 32'd9);
    check("press04_code", 32'(evt_code), 32'h04);
    check("press04_dir", 32'(evt_press), 32'd1);
    wait_drain();
    load_rep(64'h00_00_00_00_00_00_00_00);
    send_report(0); model_report();
    wait_valid(40, lat);
    check("release_latency", 32'(lat), 32'd3);
    check("release04_code", 32'(evt_code), 32'h04);
    check("release04_dir", 32'(evt_press), 32'd0);
    wait_drain();
    check("mods_after_release", 32'(modifiers), 32'h00);

    // Modifier report with backpressure on the first event.
    rdy_mode = 3; evt_ready = 1'b0;
    load_rep(64'h02_00_04_05_00_00_00_00);
    send_report(0); model_report();
    wait_valid(40, lat);
    tick(50);
    check("bp_valid", 32'(evt_valid), 32'd1);
    check("bp_code", 32'(evt_code), 32'h04);
    check("bp_modifiers", 32'(modifiers), 32'h02);
    evt_ready = 1'b1; tick(1); evt_ready = 1'b0;
    wait_valid(20, lat);
    check("bp_next_code", 32'(evt_code), 32'h05);
    check("bp_next_dir", 32'(evt_press), 32'd1);
    rdy_mode = 0; evt_ready = 1'b1;
    wait_drain();
    load_rep(64'h02_00_05_06_00_00_00_00);
    send_report(0); model_report();
    wait_drain();
    check("mods_02", 32'(modifiers), 32'h02);

    // Fragment: three bytes then silence past the gap timeout.
    load_rep(64'h00_00_1E_00_00_00_00_00);
    for (int b = 0; b < 3; b++) begin out_data = rep[b]; out_valid = 1'b1; tick(1); end
    out_valid = 1'b0;
    exp_frag++;
    tick(1020);
    check("frag_pulses", 32'(cnt_frag), 32'd1);
    send_report(0); model_report();
    wait_drain();

    // ErrorRollOver report is ignored.
    load_rep(64'h00_00_01_01_01_01_01_01);
    send_report(0); model_report();
    wait_drain();
    check("rollover_pulses", 32'(cnt_ro), 32'd1);

    // Three reports while the consumer stalls: the middle one is lost.
    rdy_mode = 1; evt_ready = 1'b0;
    load_rep(64'h00_00_07_00_00_00_00_00); send_report(0); model_report();
    load_rep(64'h00_00_08_00_00_00_00_00); send_report(0);
    load_rep(64'h00_00_09_00_00_00_00_00); send_report(0); model_report();
    exp_ovr++;
    tick(5);
    check("overrun_pulses", 32'(cnt_ovr), 32'd1);
    rdy_mode = 0; evt_ready = 1'b1;
    wait_drain();

    // Randomized reports, gaps and consumer readiness.
    rdy_mode = 2;
    for (int n = 0; n < 40; n++) begin
      rep[0] = 8'($urandom);
      rep[1] = 8'($urandom);
      for (int i = 2; i < 8; i++) rep[i] = (n % 10 == 9) ? 8'h01 : rnd_key();
      send_report(3); model_report();
      wait_drain();
    end
    rdy_mode = 0; evt_ready = 1'b1;

    // USB bus reset while an event is stalled in the press phase.
    load_rep(64'h00_00_00_00_00_00_00_00);
    send_report(0); model_report();
    wait_drain();
    rdy_mode = 1; evt_ready = 1'b0;
    load_rep(64'h02_00_04_00_00_00_00_00);
    send_report(0); model_report();
    wait_valid(40, lat);
    check("pre_rst_dir", 32'(evt_press), 32'd1);
    check("pre_rst_code", 32'(evt_code), 32'h04);
    usb_rstn = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 6; i++) m_prev[i] = 8'h00;
    m_mod = 8'h00;
    tick(1);
    check("usbrst_valid", 32'(evt_valid), 32'd0);
    check("usbrst_modifiers", 32'(modifiers), 32'd0);
    check("usbrst_code", 32'(evt_code), 32'd0);
    usb_rstn = 1'b1;
    rdy_mode = 0; evt_ready = 1'b1;
    tick(2);
    load_rep(64'h00_00_04_00_00_00_00_00);
    send_report(0); model_report();
    wait_valid(40, lat);
    check("post_rst_code", 32'(evt_code), 32'h04);
    check("post_rst_dir", 32'(evt_press), 32'd1);
    wait_drain();

    check("total_frag", 32'(cnt_frag), 32'(exp_frag));
    check("total_rollover", 32'(cnt_ro), 32'(exp_ro));
    check("total_overrun", 32'(cnt_ovr), 32'(exp_ovr));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
